// File: rtl/datapath_pkg.sv
// Shared encodings for the banked datapath: acc/register input selects, ALU codes
// and the pair-load sequencer states.
package datapath_pkg;

    localparam logic [2:0] ACC_IN_REG    = 3'd0;
    localparam logic [2:0] ACC_IN_ALU    = 3'd1;
    localparam logic [2:0] ACC_IN_IMM    = 3'd2;
    localparam logic [2:0] ACC_IN_CARRY  = 3'd3;
    localparam logic [2:0] ACC_IN_CARRY2 = 3'd4;

    localparam logic [1:0] REG_IN_ACC  = 2'd0;
    localparam logic [1:0] REG_IN_ALU  = 2'd1;
    localparam logic [1:0] REG_IN_DATA = 2'd2;

    // SUB is a + ~b + cin, so carry-out is the "no borrow" flag
    localparam logic [2:0] ALU_OP_ADD  = 3'd0;
    localparam logic [2:0] ALU_OP_SUB  = 3'd1;
    localparam logic [2:0] ALU_OP_AND  = 3'd2;
    localparam logic [2:0] ALU_OP_OR   = 3'd3;
    localparam logic [2:0] ALU_OP_XOR  = 3'd4;
    localparam logic [2:0] ALU_OP_PASS = 3'd5;

    localparam logic [1:0] ALU_IN_ACC  = 2'd0;
    localparam logic [1:0] ALU_IN_REG  = 2'd1;
    localparam logic [1:0] ALU_IN_DATA = 2'd2;
    localparam logic [1:0] ALU_IN_IMM  = 2'd3;

    localparam logic [1:0] CIN_ZERO   = 2'd0;
    localparam logic [1:0] CIN_ONE    = 2'd1;
    localparam logic [1:0] CIN_CARRY  = 2'd2;
    localparam logic [1:0] CIN_NCARRY = 2'd3;

    typedef enum logic [1:0] {
        PAIR_IDLE = 2'd0,
        PAIR_HI   = 2'd1,
        PAIR_LO   = 2'd2
    } pair_state_e;

endpackage

// File: rtl/datapath_banked_alu_w.sv
// Combinational WIDTH-bit ALU; bit WIDTH of the result is the carry-out.
module alu_w
    import datapath_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH:0]   y
);

    always_comb begin
        y = 'x;
        case (op)
            ALU_OP_ADD:  y = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
            ALU_OP_SUB:  y = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(cin);
            ALU_OP_AND:  y = {1'b0, a & b};
            ALU_OP_OR:   y = {1'b0, a | b};
            ALU_OP_XOR:  y = {1'b0, a ^ b};
            ALU_OP_PASS: y = {1'b0, a};
            default:     y = 'x;
        endcase
    end

endmodule

// File: rtl/datapath_banked.sv
// Banked accumulator/carry/register-file datapath with a two-cycle pair-load sequencer.
// Optional context shadow enabled by defining DATAPATH_SHADOW_EN.
module datapath_banked
    import datapath_pkg::*;
#(
    parameter  int WIDTH     = 4,
    parameter  int NUM_REGS  = 16,
    parameter  int NUM_BANKS = 2,
    localparam int RIDX_W    = $clog2(NUM_REGS),
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [WIDTH-1:0]    data,
    input  logic [RIDX_W-1:0]   inst_operand,
    input  logic                clear_carry,
    input  logic                write_carry,
    input  logic                clear_accumulator,
    input  logic                write_accumulator,
    input  logic [2:0]          acc_input_sel,
    input  logic                write_register,
    input  logic [1:0]          reg_input_sel,
    input  logic [2:0]          alu_op,
    input  logic [1:0]          alu_in0_sel,
    input  logic [1:0]          alu_in1_sel,
    input  logic [1:0]          alu_cin_sel,
    input  logic                bank_write,
    input  logic [BANK_W-1:0]   bank_in,
    input  logic                pair_load,
    input  logic                save_ctx,
    input  logic                restore_ctx,
    output logic [WIDTH-1:0]    regval,
    output logic [2*WIDTH-1:0]  pair_val,
    output logic [WIDTH-1:0]    acc_out,
    output logic                carry_out,
    output logic [BANK_W-1:0]   bank_sel,
    output logic                pair_busy,
    output logic                shadow_valid
);

    localparam logic [BANK_W-1:0] BANK_MASK = BANK_W'(NUM_BANKS - 1);

    logic [NUM_BANKS-1:0][NUM_REGS-1:0][WIDTH-1:0] rf;
    logic [WIDTH-1:0]  acc_q, acc_nx, acc_in, reg_wr_val, imm;
    logic              carry_q, carry_nx, alu_cin;
    logic [BANK_W-1:0] bank_q, bank_nx;
    logic [WIDTH-1:0]  alu_a, alu_b;
    logic [WIDTH:0]    alu_res;
    logic [RIDX_W-1:0] pair_hi_idx, pair_lo_idx;

    pair_state_e       state_q, state_d;
    logic [RIDX_W-1:0] pair_base_q, pair_wr_idx;
    logic [BANK_W-1:0] pair_bank_q;

    assign imm         = WIDTH'(inst_operand);
    assign pair_hi_idx = inst_operand & ~RIDX_W'(1);
    assign pair_lo_idx = inst_operand | RIDX_W'(1);

    assign regval    = rf[bank_q][inst_operand];
    assign pair_val  = {rf[bank_q][pair_hi_idx], rf[bank_q][pair_lo_idx]};
    assign acc_out   = acc_q;
    assign carry_out = carry_q;
    assign bank_sel  = bank_q;
    assign pair_busy = (state_q != PAIR_IDLE);

    always_comb begin
        alu_a = 'x;
        case (alu_in0_sel)
            ALU_IN_ACC:  alu_a = acc_q;
            ALU_IN_REG:  alu_a = regval;
            ALU_IN_DATA: alu_a = data;
            ALU_IN_IMM:  alu_a = imm;
            default:     alu_a = 'x;
        endcase
        alu_b = 'x;
        case (alu_in1_sel)
            ALU_IN_ACC:  alu_b = acc_q;
            ALU_IN_REG:  alu_b = regval;
            ALU_IN_DATA: alu_b = data;
            ALU_IN_IMM:  alu_b = imm;
            default:     alu_b = 'x;
        endcase
        alu_cin = 1'bx;
        case (alu_cin_sel)
            CIN_ZERO:   alu_cin = 1'b0;
            CIN_ONE:    alu_cin = 1'b1;
            CIN_CARRY:  alu_cin = carry_q;
            CIN_NCARRY: alu_cin = ~carry_q;
            default:    alu_cin = 1'bx;
        endcase
    end

    alu_w #(.WIDTH(WIDTH)) u_alu (
        .op  (alu_op),
        .a   (alu_a),
        .b   (alu_b),
        .cin (alu_cin),
        .y   (alu_res)
    );

    always_comb begin
        acc_in = 'x;
        case (acc_input_sel)
            ACC_IN_REG:    acc_in = regval;
            ACC_IN_ALU:    acc_in = alu_res[WIDTH-1:0];
            ACC_IN_IMM:    acc_in = imm;
            ACC_IN_CARRY:  acc_in = WIDTH'(carry_q);
            ACC_IN_CARRY2: acc_in = carry_q ? WIDTH'(10) : WIDTH'(9);
            default:       acc_in = 'x;
        endcase
        reg_wr_val = 'x;
        case (reg_input_sel)
            REG_IN_ACC:  reg_wr_val = acc_q;
            REG_IN_ALU:  reg_wr_val = alu_res[WIDTH-1:0];
            REG_IN_DATA: reg_wr_val = data;
            default:     reg_wr_val = 'x;
        endcase
    end

`ifdef DATAPATH_SHADOW_EN
    logic [WIDTH-1:0]  sh_acc;
    logic              sh_carry, sh_valid_q;
    logic [BANK_W-1:0] sh_bank;
    logic              do_restore;

    assign do_restore   = restore_ctx && sh_valid_q;
    assign shadow_valid = sh_valid_q;

    // A pending restore suppresses a same-cycle save, whether or not it takes effect
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_acc     <= '0;
            sh_carry   <= 1'b0;
            sh_bank    <= '0;
            sh_valid_q <= 1'b0;
        end else if (do_restore) begin
            sh_valid_q <= 1'b0;
        end else if (save_ctx && !restore_ctx) begin
            sh_acc     <= acc_q;
            sh_carry   <= carry_q;
            sh_bank    <= bank_q;
            sh_valid_q <= 1'b1;
        end
    end
`else
    logic unused_ctx;
    assign unused_ctx   = save_ctx ^ restore_ctx;
    assign shadow_valid = 1'b0;
`endif

    always_comb begin
        acc_nx   = acc_q;
        carry_nx = carry_q;
        bank_nx  = bank_q;
        if (clear_accumulator)      acc_nx = '0;
        else if (write_accumulator) acc_nx = acc_in;
        if (clear_carry)            carry_nx = 1'b0;
        else if (write_carry)       carry_nx = alu_res[WIDTH];
        if (bank_write)             bank_nx = bank_in & BANK_MASK;
`ifdef DATAPATH_SHADOW_EN
        if (do_restore) begin
            acc_nx   = sh_acc;
            carry_nx = sh_carry;
            bank_nx  = sh_bank;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            carry_q <= 1'b1;
            bank_q  <= '0;
        end else begin
            acc_q   <= acc_nx;
            carry_q <= carry_nx;
            bank_q  <= bank_nx;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PAIR_IDLE: if (pair_load) state_d = PAIR_HI;
            PAIR_HI:   state_d = PAIR_LO;
            PAIR_LO:   state_d = PAIR_IDLE;
            default:   state_d = PAIR_IDLE;
        endcase
    end

    assign pair_wr_idx = (state_q == PAIR_HI) ? pair_base_q : (pair_base_q | RIDX_W'(1));

    // Pair index and bank are captured at start so later bank_write does not redirect it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= PAIR_IDLE;
            pair_base_q <= '0;
            pair_bank_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == PAIR_IDLE && pair_load) begin
                pair_base_q <= pair_hi_idx;
                pair_bank_q <= bank_q;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)               rf <= '0;
        else if (pair_busy)      rf[pair_bank_q][pair_wr_idx] <= data;
        else if (write_register) rf[bank_q][inst_operand] <= reg_wr_val;
    end

endmodule

// File: tb/tb_datapath_banked.sv
// Randomized + directed bench for datapath_banked against a queue/array reference model.
module tb_datapath_banked;
    import datapath_pkg::*;

    localparam int W = 4, NR = 16, NB = 2, RW = 4, BW = 1;
    localparam int MOD = 1 << W;

    logic clock = 1'b0, reset = 1'b0;
    logic [W-1:0]   data;
    logic [RW-1:0]  inst_operand;
    logic clear_carry, write_carry, clear_accumulator, write_accumulator;
    logic [2:0] acc_input_sel, alu_op;
    logic write_register;
    logic [1:0] reg_input_sel, alu_in0_sel, alu_in1_sel, alu_cin_sel;
    logic bank_write;
    logic [BW-1:0] bank_in;
    logic pair_load, save_ctx, restore_ctx;
    logic [W-1:0]   regval, acc_out;
    logic [2*W-1:0] pair_val;
    logic carry_out, pair_busy, shadow_valid;
    logic [BW-1:0] bank_sel;

    datapath_banked #(.WIDTH(W), .NUM_REGS(NR), .NUM_BANKS(NB)) dut (
        .clock(clock), .reset(reset), .data(data), .inst_operand(inst_operand),
        .clear_carry(clear_carry), .write_carry(write_carry),
        .clear_accumulator(clear_accumulator), .write_accumulator(write_accumulator),
        .acc_input_sel(acc_input_sel), .write_register(write_register),
        .reg_input_sel(reg_input_sel), .alu_op(alu_op), .alu_in0_sel(alu_in0_sel),
        .alu_in1_sel(alu_in1_sel), .alu_cin_sel(alu_cin_sel), .bank_write(bank_write),
        .bank_in(bank_in), .pair_load(pair_load), .save_ctx(save_ctx),
        .restore_ctx(restore_ctx), .regval(regval), .pair_val(pair_val),
        .acc_out(acc_out), .carry_out(carry_out), .bank_sel(bank_sel),
        .pair_busy(pair_busy), .shadow_valid(shadow_valid)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0;

    // Reference state: plain arrays plus a queue of pending pair writes
    int m_rf [NB][NR];
    int m_acc, m_carry, m_bank, m_sv, sh_acc, sh_carry, sh_bank;
    int q_bank[$], q_idx[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_rf[b, r]) m_rf[b][r] = 0;
        m_acc = 0; m_carry = 1; m_bank = 0; m_sv = 0;
        sh_acc = 0; sh_carry = 0; sh_bank = 0;
        q_bank.delete(); q_idx.delete();
    endtask

    function automatic int opv(input logic [1:0] sel, input int rv);
        case (sel)
            ALU_IN_ACC:  return m_acc;
            ALU_IN_REG:  return rv;
            ALU_IN_DATA: return int'(data);
            default:     return int'(inst_operand);
        endcase
    endfunction

    task automatic model_step();
        int rv, a, b, ci, s, r, co, accin, regin, n_acc, n_carry, n_bank, op;
        bit restored;
        op = int'(inst_operand);
        rv = m_rf[m_bank][op];
        a = opv(alu_in0_sel, rv);
        b = opv(alu_in1_sel, rv);
        case (alu_cin_sel)
            CIN_ZERO:  ci = 0;
            CIN_ONE:   ci = 1;
            CIN_CARRY: ci = m_carry;
            default:   ci = 1 - m_carry;
        endcase
        case (alu_op)
            ALU_OP_ADD: s = a + b + ci;
            ALU_OP_SUB: s = a + (MOD - 1 - b) + ci;
            ALU_OP_AND: s = a & b;
            ALU_OP_OR:  s = a | b;
            ALU_OP_XOR: s = a ^ b;
            default:    s = a;
        endcase
        r = s % MOD;
        co = s / MOD;
        case (acc_input_sel)
            ACC_IN_REG:   accin = rv;
            ACC_IN_ALU:   accin = r;
            ACC_IN_IMM:   accin = op;
            ACC_IN_CARRY: accin = m_carry;
            default:      accin = m_carry ? 10 : 9;
        endcase
        case (reg_input_sel)
            REG_IN_ACC: regin = m_acc;
            REG_IN_ALU: regin = r;
            default:    regin = int'(data);
        endcase
        n_acc   = clear_accumulator ? 0 : (write_accumulator ? accin : m_acc);
        n_carry = clear_carry ? 0 : (write_carry ? co : m_carry);
        n_bank  = bank_write ? int'(bank_in) % NB : m_bank;
        if (q_idx.size() != 0) begin
            m_rf[q_bank[0]][q_idx[0]] = int'(data);
            void'(q_bank.pop_front());
            void'(q_idx.pop_front());
        end else begin
            if (write_register) m_rf[m_bank][op] = regin;
            if (pair_load) begin
                q_bank.push_back(m_bank); q_idx.push_back((op / 2) * 2);
                q_bank.push_back(m_bank); q_idx.push_back((op / 2) * 2 + 1);
            end
        end
        restored = 0;
`ifdef DATAPATH_SHADOW_EN
        if (restore_ctx && m_sv == 1) begin
            n_acc = sh_acc; n_carry = sh_carry; n_bank = sh_bank;
            m_sv = 0; restored = 1;
        end else if (save_ctx && !restore_ctx) begin
            sh_acc = m_acc; sh_carry = m_carry; sh_bank = m_bank; m_sv = 1;
        end
`endif
        if (restored) m_sv = 0;
        m_acc = n_acc; m_carry = n_carry; m_bank = n_bank;
    endtask

    task automatic check_all();
        int op;
        op = int'(inst_operand);
        chk("acc", acc_out, m_acc);
        chk("carry", carry_out, m_carry);
        chk("bank_sel", bank_sel, m_bank);
        chk("pair_busy", pair_busy, q_idx.size() != 0);
        chk("regval", regval, m_rf[m_bank][op]);
        chk("pair_val", pair_val, m_rf[m_bank][(op / 2) * 2] * MOD + m_rf[m_bank][(op / 2) * 2 + 1]);
        chk("shadow_valid", shadow_valid, m_sv);
    endtask

    task automatic idle();
        data = '0; inst_operand = '0;
        clear_carry = 0; write_carry = 0; clear_accumulator = 0; write_accumulator = 0;
        acc_input_sel = ACC_IN_REG; write_register = 0; reg_input_sel = REG_IN_ACC;
        alu_op = ALU_OP_ADD; alu_in0_sel = ALU_IN_ACC; alu_in1_sel = ALU_IN_REG;
        alu_cin_sel = CIN_ZERO; bank_write = 0; bank_in = '0;
        pair_load = 0; save_ctx = 0; restore_ctx = 0;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clock);
        #1;
        check_all();
        idle();
    endtask

    task automatic rand_cycle();
        int k;
        data = W'($urandom); inst_operand = RW'($urandom);
        clear_carry = ($urandom_range(0, 7) == 0); write_carry = $urandom_range(0, 1);
        clear_accumulator = ($urandom_range(0, 7) == 0); write_accumulator = $urandom_range(0, 1);
        acc_input_sel = 3'($urandom_range(0, 4)); write_register = $urandom_range(0, 1);
        reg_input_sel = 2'($urandom_range(0, 2)); alu_op = 3'($urandom_range(0, 5));
        alu_in0_sel = 2'($urandom); alu_in1_sel = 2'($urandom); alu_cin_sel = 2'($urandom);
        bank_write = ($urandom_range(0, 3) == 0); bank_in = BW'($urandom);
        pair_load = ($urandom_range(0, 5) == 0);
        k = $urandom_range(0, 5);
        save_ctx = (k == 0); restore_ctx = (k == 1);
        cyc();
    endtask

    initial begin
        idle();
        model_reset();
        #2 reset = 1;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        check_all();

        repeat (80) rand_cycle();
        repeat (3) cyc();

        // acc=F, carry=0, ADD reg=1 with write_carry
        bank_write = 1; bank_in = 0; cyc();
        write_register = 1; inst_operand = 1; reg_input_sel = REG_IN_DATA; data = 1; cyc();
        clear_carry = 1; write_accumulator = 1; acc_input_sel = ACC_IN_IMM; inst_operand = 15; cyc();
        chk("acc_preset", acc_out, 15);
        chk("carry_preset", carry_out, 0);
        inst_operand = 1; alu_op = ALU_OP_ADD; alu_in0_sel = ALU_IN_ACC; alu_in1_sel = ALU_IN_REG;
        alu_cin_sel = CIN_CARRY; write_accumulator = 1; acc_input_sel = ACC_IN_ALU; write_carry = 1;
        cyc();
        chk("add_wrap_acc", acc_out, 0);
        chk("add_wrap_carry", carry_out, 1);

        // per-bank register visibility
        write_register = 1; inst_operand = 3; reg_input_sel = REG_IN_DATA; data = 5; cyc();
        bank_write = 1; bank_in = 1; cyc();
        write_register = 1; inst_operand = 3; reg_input_sel = REG_IN_DATA; data = 4'hA; cyc();
        inst_operand = 3; #1;
        chk("bank1_r3", regval, 4'hA);
        bank_write = 1; bank_in = 0; inst_operand = 3; cyc();
        inst_operand = 3; #1;
        chk("bank0_r3", regval, 5);

        // pair load p=2
        pair_load = 1; inst_operand = 4; cyc();
        chk("pair_busy_c1", pair_busy, 1);
        data = 4'h7; cyc();
        chk("pair_busy_c2", pair_busy, 1);
        data = 4'hC; cyc();
        chk("pair_busy_done", pair_busy, 0);
        inst_operand = 4; #1;
        chk("pair_val_7c", pair_val, 8'h7C);

        // write_register and a second pair_load during HI are both dropped
        pair_load = 1; inst_operand = 4; cyc();
        data = 4'h9; write_register = 1; reg_input_sel = REG_IN_ACC; inst_operand = 4;
        pair_load = 1; cyc();
        data = 4'hE; cyc();
        cyc();
        chk("pair_no_restart", pair_busy, 0);
        inst_operand = 4; #1;
        chk("pair_val_9e", pair_val, 8'h9E);

        // context save / restore
        alu_op = ALU_OP_ADD; alu_in0_sel = ALU_IN_IMM; alu_in1_sel = ALU_IN_IMM;
        alu_cin_sel = CIN_ZERO; inst_operand = 15; write_carry = 1; cyc();
        write_accumulator = 1; acc_input_sel = ACC_IN_IMM; inst_operand = 3;
        bank_write = 1; bank_in = 1; cyc();
        save_ctx = 1; cyc();
        clear_accumulator = 1; clear_carry = 1; bank_write = 1; bank_in = 0; cyc();
        restore_ctx = 1; write_accumulator = 1; acc_input_sel = ACC_IN_IMM; inst_operand = 7; cyc();
`ifdef DATAPATH_SHADOW_EN
        chk("restore_acc", acc_out, 3);
        chk("restore_carry", carry_out, 1);
        chk("restore_bank", bank_sel, 1);
        chk("restore_sv", shadow_valid, 0);
`else
        chk("noshadow_acc", acc_out, 7);
        chk("noshadow_sv", shadow_valid, 0);
`endif

        // asynchronous reset while the pair sequencer is in HI
        write_accumulator = 1; acc_input_sel = ACC_IN_IMM; inst_operand = 6; cyc();
        pair_load = 1; inst_operand = 2; cyc();
        chk("pre_reset_busy", pair_busy, 1);
        #1 reset = 1;
        model_reset();
        #1;
        chk("rst_busy", pair_busy, 0);
        chk("rst_acc", acc_out, 0);
        chk("rst_carry", carry_out, 1);
        chk("rst_bank", bank_sel, 0);
        for (int i = 0; i < NR; i++) begin
            inst_operand = RW'(i); #1;
            chk("rst_bank0_reg", regval, 0);
        end
        @(posedge clock);
        #1 reset = 0;
        idle();
        check_all();
        bank_write = 1; bank_in = 1; cyc();
        for (int i = 0; i < NR; i++) begin
            inst_operand = RW'(i); #1;
            chk("rst_bank1_reg", regval, 0);
        end
        idle();

        repeat (40) rand_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
